// File: rtl/route_dec_pkg.sv
// Shared definitions for the router input-port route decrement stage.
// Build option: ROUTE_DEC_YX_FIRST_EN selects Y-before-X routing in hop_dec.
package route_dec_pkg;

    // Flit type codes carried on in_typ/out_typ
    localparam logic [1:0] FT_SINGLE = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b10;
    localparam logic [1:0] FT_TAIL   = 2'b11;

    // One-hot output port selects
    localparam logic [4:0] P_E = 5'b00001;
    localparam logic [4:0] P_W = 5'b00010;
    localparam logic [4:0] P_N = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000;
    localparam logic [4:0] P_L = 5'b10000;

    // Packet tracking states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/hop_dec.sv
// Combinational hop decrementer and output port selector.
// Default is XY order; defining ROUTE_DEC_YX_FIRST_EN routes the Y dimension first.
// A zero hop count is never decremented, so no underflow can occur.
module hop_dec
    import route_dec_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0] xh,
    input  logic          xdir,
    input  logic [AW-1:0] yh,
    input  logic          ydir,
    output logic [AW-1:0] xh_out,
    output logic [AW-1:0] yh_out,
    output logic [4:0]    port
);

    localparam logic [AW-1:0] HOP_ONE  = AW'(1'b1);
    localparam logic [AW-1:0] HOP_ZERO = {AW{1'b0}};

    // Pick the active dimension, decrement its hop count and choose the port
    always_comb begin
        xh_out = xh;
        yh_out = yh;
        port   = P_L;
`ifdef ROUTE_DEC_YX_FIRST_EN
        if (yh != HOP_ZERO) begin
            yh_out = yh - HOP_ONE;
            port   = ydir ? P_S : P_N;
        end else if (xh != HOP_ZERO) begin
            xh_out = xh - HOP_ONE;
            port   = xdir ? P_W : P_E;
        end else begin
            port   = P_L;
        end
`else
        if (xh != HOP_ZERO) begin
            xh_out = xh - HOP_ONE;
            port   = xdir ? P_W : P_E;
        end else if (yh != HOP_ZERO) begin
            yh_out = yh - HOP_ONE;
            port   = ydir ? P_S : P_N;
        end else begin
            port   = P_L;
        end
`endif
    end

endmodule

// File: rtl/route_dec_stage.sv
// Registered route decrement stage for a router input port.
// Head/single flits are routed by hop_dec; body/tail flits reuse the head's
// latched port. One valid/ready register stage with full throughput.
// Build option: ROUTE_DEC_YX_FIRST_EN (handled inside hop_dec).
module route_dec_stage
    import route_dec_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [1:0]    in_typ,
    input  logic [DW-1:0] in_dat,
    output logic          in_rdy,
    output logic          out_vld,
    output logic [1:0]    out_typ,
    output logic [DW-1:0] out_dat,
    output logic [4:0]    out_port,
    input  logic          out_rdy,
    output logic          err
);

    if (DW < 2*AW+2) begin : g_bad_dw
        $error("route_dec_stage: DW must be at least 2*AW+2");
    end

    state_t        state_r;
    state_t        state_nx_s;
    logic [4:0]    port_lat_r;
    logic          xfer_s;
    logic [AW-1:0] xh_out_s;
    logic [AW-1:0] yh_out_s;
    logic [4:0]    hd_port_s;
    logic [DW-1:0] upd_dat_s;
    logic          emit_s;
    logic          viol_s;
    logic          load_lat_s;
    logic [4:0]    nx_port_s;
    logic [DW-1:0] nx_dat_s;

    assign in_rdy = !out_vld || out_rdy;
    assign xfer_s = in_vld && in_rdy;

    hop_dec #(.AW(AW)) u_hop_dec (
        .xh     (in_dat[AW-1:0]),
        .xdir   (in_dat[AW]),
        .yh     (in_dat[2*AW:AW+1]),
        .ydir   (in_dat[2*AW+1]),
        .xh_out (xh_out_s),
        .yh_out (yh_out_s),
        .port   (hd_port_s)
    );

    // Merge decremented hop counts back into the payload; direction and upper bits pass through
    always_comb begin
        upd_dat_s               = in_dat;
        upd_dat_s[AW-1:0]       = xh_out_s;
        upd_dat_s[2*AW:AW+1]    = yh_out_s;
    end

    // Packet FSM: decide emission, violation, port latch and next state for an accepted flit
    always_comb begin
        state_nx_s = state_r;
        emit_s     = 1'b0;
        viol_s     = 1'b0;
        load_lat_s = 1'b0;
        nx_port_s  = port_lat_r;
        nx_dat_s   = in_dat;
        if (xfer_s) begin
            case (in_typ)
                FT_SINGLE: begin
                    viol_s     = (state_r == ST_PKT);
                    emit_s     = 1'b1;
                    nx_port_s  = hd_port_s;
                    nx_dat_s   = upd_dat_s;
                    state_nx_s = ST_IDLE;
                end
                FT_HEAD: begin
                    viol_s     = (state_r == ST_PKT);
                    emit_s     = 1'b1;
                    load_lat_s = 1'b1;
                    nx_port_s  = hd_port_s;
                    nx_dat_s   = upd_dat_s;
                    state_nx_s = ST_PKT;
                end
                FT_BODY: begin
                    if (state_r == ST_PKT) begin
                        emit_s = 1'b1;
                    end else begin
                        viol_s = 1'b1;
                    end
                end
                FT_TAIL: begin
                    if (state_r == ST_PKT) begin
                        emit_s     = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        viol_s     = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Packet state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Hold the head's port for the body and tail flits of the packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_lat_r <= 5'b00000;
        end else if (load_lat_s) begin
            port_lat_r <= hd_port_s;
        end
    end

    // Output register: load on an emitting transfer, clear valid once drained, pulse err on violations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_typ  <= 2'b00;
            out_dat  <= {DW{1'b0}};
            out_port <= 5'b00000;
            err      <= 1'b0;
        end else begin
            if (xfer_s && emit_s) begin
                out_vld  <= 1'b1;
                out_typ  <= in_typ;
                out_dat  <= nx_dat_s;
                out_port <= nx_port_s;
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end
            err <= viol_s;
        end
    end

endmodule

// File: tb/tb_route_dec_stage.sv
// Self-checking bench for route_dec_stage (AW=8, DW=32): directed vectors plus
// a scoreboard fed by a reference model at every accepted input flit.
// Honours ROUTE_DEC_YX_FIRST_EN for the routing-order dependent expectations.
module tb_route_dec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic [1:0]  in_typ = 2'b00;
    logic [31:0] in_dat = 32'h0;
    logic        in_rdy;
    logic        out_vld;
    logic [1:0]  out_typ;
    logic [31:0] out_dat;
    logic [4:0]  out_port;
    logic        out_rdy = 1'b1;
    logic        err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] dat;
        logic [4:0]  port;
    } exp_t;

    exp_t       sb[$];
    logic       m_pkt = 1'b0;
    logic [4:0] m_lp = 5'b00000;
    logic       err_exp = 1'b0;
    logic       rnd_rdy = 1'b0;
    logic       rdy_val = 1'b1;

    route_dec_stage #(.AW(8), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_typ   (in_typ),
        .in_dat   (in_dat),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_typ  (out_typ),
        .out_dat  (out_dat),
        .out_port (out_port),
        .out_rdy  (out_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [13:0] up, input logic yd, input logic [7:0] y,
                                       input logic xd, input logic [7:0] x);
        return {up, yd, y, xd, x};
    endfunction

    function automatic exp_t route(input logic [1:0] typ, input logic [31:0] d);
        exp_t r;
        logic [7:0] x;
        logic [7:0] y;
        x = d[7:0];
        y = d[16:9];
        r.typ = typ;
        r.dat = d;
        r.port = 5'b10000;
`ifdef ROUTE_DEC_YX_FIRST_EN
        if (y != 8'd0) begin
            r.dat[16:9] = y - 8'd1;
            r.port = d[17] ? 5'b01000 : 5'b00100;
        end else if (x != 8'd0) begin
            r.dat[7:0] = x - 8'd1;
            r.port = d[8] ? 5'b00010 : 5'b00001;
        end
`else
        if (x != 8'd0) begin
            r.dat[7:0] = x - 8'd1;
            r.port = d[8] ? 5'b00010 : 5'b00001;
        end else if (y != 8'd0) begin
            r.dat[16:9] = y - 8'd1;
            r.port = d[17] ? 5'b01000 : 5'b00100;
        end
`endif
        return r;
    endfunction

    // Downstream ready driver: fixed level or random per cycle
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: check handshake/err/output against the model, then advance the model
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_pkt   = 1'b0;
            m_lp    = 5'b00000;
            err_exp = 1'b0;
        end else begin
            chk("out_vld", out_vld, (sb.size() != 0));
            chk("in_rdy", in_rdy, (sb.size() == 0) || out_rdy);
            chk("err", err, err_exp);
            if (out_vld && sb.size() != 0) begin
                chk("out_typ", out_typ, sb[0].typ);
                chk("out_dat", out_dat, sb[0].dat);
                chk("out_port", out_port, sb[0].port);
                if (out_rdy) void'(sb.pop_front());
            end
            err_exp = 1'b0;
            if (in_vld && in_rdy) begin
                case (in_typ)
                    2'b00, 2'b01: begin
                        if (m_pkt) err_exp = 1'b1;
                        e = route(in_typ, in_dat);
                        sb.push_back(e);
                        if (in_typ == 2'b01) begin
                            m_pkt = 1'b1;
                            m_lp  = e.port;
                        end else begin
                            m_pkt = 1'b0;
                        end
                    end
                    default: begin
                        if (!m_pkt) begin
                            err_exp = 1'b1;
                        end else begin
                            e.typ = in_typ;
                            e.dat = in_dat;
                            e.port = m_lp;
                            sb.push_back(e);
                            if (in_typ == 2'b11) m_pkt = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Present one flit and hold it until accepted; called and returns at posedge+1
    task automatic send(input logic [1:0] t, input logic [31:0] d);
        int n;
        logic ok;
        in_vld = 1'b1;
        in_typ = t;
        in_dat = d;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_rdy;
            n++;
            @(posedge clk);
            #1;
        end
        chk("send_timeout", ok, 1'b1);
        in_vld = 1'b0;
    endtask

    // Check the flit just loaded into the output register against constants
    task automatic see(input string tag, input logic [4:0] p, input logic [31:0] d);
        chk({tag, "_vld"}, out_vld, 1'b1);
        chk({tag, "_port"}, out_port, p);
        chk({tag, "_dat"}, out_dat, d);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vld"}, out_vld, 1'b0);
        chk({tag, "_typ"}, out_typ, 2'b00);
        chk({tag, "_dat"}, out_dat, 32'h0);
        chk({tag, "_port"}, out_port, 5'b00000);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_rdy"}, in_rdy, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #13;
        chk_reset_outs("rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single flit with both dimensions nonzero
        send(2'b00, mk(14'h2ABC, 1'b0, 8'd2, 1'b0, 8'd3));
`ifdef ROUTE_DEC_YX_FIRST_EN
        see("single_xy", 5'b00100, mk(14'h2ABC, 1'b0, 8'd1, 1'b0, 8'd3));
`else
        see("single_xy", 5'b00001, mk(14'h2ABC, 1'b0, 8'd2, 1'b0, 8'd2));
`endif

        // Head to South then body, body, tail on the latched port
        send(2'b01, mk(14'h0155, 1'b1, 8'd1, 1'b0, 8'd0));
        see("head_s", 5'b01000, mk(14'h0155, 1'b1, 8'd0, 1'b0, 8'd0));
        send(2'b10, 32'hDEAD_BEEF);
        see("body1", 5'b01000, 32'hDEAD_BEEF);
        send(2'b10, 32'h0000_0001);
        see("body2", 5'b01000, 32'h0000_0001);
        send(2'b11, 32'hFFFF_FFFF);
        see("tail", 5'b01000, 32'hFFFF_FFFF);

        // Body while idle: dropped, err for exactly one cycle
        send(2'b10, 32'h1234_5678);
        chk("idle_body_err", err, 1'b1);
        chk("idle_body_vld", out_vld, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_body_err_off", err, 1'b0);

        // Local delivery and maximum hop counts
        send(2'b00, mk(14'h3FFF, 1'b1, 8'd0, 1'b0, 8'd0));
        see("local", 5'b10000, mk(14'h3FFF, 1'b1, 8'd0, 1'b0, 8'd0));
        send(2'b00, mk(14'h0000, 1'b0, 8'd255, 1'b0, 8'd255));
`ifdef ROUTE_DEC_YX_FIRST_EN
        see("max", 5'b00100, mk(14'h0000, 1'b0, 8'd254, 1'b0, 8'd255));
`else
        see("max", 5'b00001, mk(14'h0000, 1'b0, 8'd255, 1'b0, 8'd254));
`endif
        send(2'b00, mk(14'h0000, 1'b0, 8'd1, 1'b0, 8'd1));
`ifdef ROUTE_DEC_YX_FIRST_EN
        see("one_one", 5'b00100, mk(14'h0000, 1'b0, 8'd0, 1'b0, 8'd1));
`else
        see("one_one", 5'b00001, mk(14'h0000, 1'b0, 8'd1, 1'b0, 8'd0));
`endif
        @(posedge clk);
        #1;

        // Backpressure: stream while downstream stalls
        rdy_val = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(2'b00, mk(14'(i), 1'b0, 8'(i), 1'b1, 8'(i + 1)));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_in_rdy", in_rdy, 1'b0);
                chk("stall_out_vld", out_vld, 1'b1);
                rdy_val = 1'b1;
            end
        join

        // Random traffic with random downstream ready
        rnd_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(2'($urandom_range(0, 3)), $urandom);
        end
        rnd_rdy = 1'b0;
        rdy_val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", out_vld, 1'b0);

        // Reset in the middle of a packet with output pending
        send(2'b01, mk(14'h0000, 1'b0, 8'd0, 1'b1, 8'd5));
        see("rst_head", 5'b00010, mk(14'h0000, 1'b0, 8'd0, 1'b1, 8'd4));
        send(2'b10, 32'hCAFE_0000);
        rdy_val = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        send(2'b10, 32'h0BAD_0BAD);
        chk("post_rst_body_err", err, 1'b1);
        chk("post_rst_body_vld", out_vld, 1'b0);
        send(2'b01, mk(14'h0001, 1'b0, 8'd3, 1'b0, 8'd0));
        see("post_rst_head", 5'b00100, mk(14'h0001, 1'b0, 8'd2, 1'b0, 8'd0));
        send(2'b11, 32'h7777_7777);
        see("post_rst_tail", 5'b00100, 32'h7777_7777);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
